tick_generator: RTL and testbench

TICK_GENERATOR -- requirements
Module: tick_generator

---
 rtl/tick_generator_pkg.sv | 27 ++
 rtl/tick_channel.sv | 91 +++++++++
 rtl/tick_generator.sv | 42 ++++
 tb/tb_tick_generator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_generator_pkg.sv
// Shared constants for the tick generator: widths, channel count and the reset divisors
// derived from the system clock and the target rates.
package tick_generator_pkg;

    localparam int unsigned CntWidth    = 16;
    localparam int unsigned NumChannels = 4;
    localparam int unsigned ChanIdxW    = 4;

    localparam int unsigned SysClkHz = 20_000_000;
    localparam int unsigned CpuClkHz = 4_000_000;
    localparam int unsigned PerClkHz = 1_000_000;
    localparam int unsigned RtcClkHz = 1_000_000;
    localparam int unsigned BaudRate = 115_200;

    typedef logic [CntWidth-1:0] div_t;

    // Truncating divide: the bit channel runs slightly fast rather than slow.
    function automatic div_t calc_div(input int unsigned freq_hz);
        return div_t'(SysClkHz / freq_hz);
    endfunction

    // Channel order: cpu, per, rtc, bit (index 0 in the low slice).
    localparam logic [NumChannels-1:0][CntWidth-1:0] DivInit = {
        calc_div(BaudRate), calc_div(RtcClkHz), calc_div(PerClkHz), calc_div(CpuClkHz)
    };

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counts to div_q-1, emits a registered tick and toggles level on wrap.
module tick_channel
    import tick_generator_pkg::*;
#(
    parameter int unsigned          cnt_width = CntWidth,
    parameter logic [cnt_width-1:0] div_init  = cnt_width'(1)
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 wr_i,
    input  logic                 wr_now_i,
    input  logic [cnt_width-1:0] wr_data_i,
    input  logic                 align_i,
    output logic                 tick_o,
    output logic                 level_o,
    output logic                 pend_o
);

    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [cnt_width-1:0] div_q, div_d;
    logic [cnt_width-1:0] divp_q, divp_d;
    logic                 pend_q, pend_d;
    logic                 tick_q, tick_d;
    logic                 level_q, level_d;
    logic                 enabled;
    logic                 wrap;

    assign enabled = (div_q != '0);
    assign wrap    = enabled && (cnt_q == div_q - cnt_width'(1));

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        divp_d  = divp_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        level_d = level_q;
        if (wr_i && (wr_now_i || align_i || !enabled)) begin
            // Restart with the written divisor; any deferred value is dropped.
            div_d  = wr_data_i;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (align_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (pend_q) begin
                div_d = divp_q;
            end
        end else if (enabled) begin
            if (wrap) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                level_d = ~level_q;
                if (pend_q) begin
                    div_d  = divp_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + cnt_width'(1);
            end
            // A deferred write on the wrap cycle queues behind the value consumed now.
            if (wr_i) begin
                divp_d = wr_data_i;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            div_q   <= div_init;
            divp_q  <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            divp_q  <= divp_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick_o  = tick_q;
    assign level_o = level_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator: decodes divisor writes and fans align out to each channel.
module tick_generator
    import tick_generator_pkg::*;
#(
    parameter int unsigned                        channels  = NumChannels,
    parameter int unsigned                        cnt_width = CntWidth,
    parameter logic [channels-1:0][cnt_width-1:0] div_init  = DivInit
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 wr_en_i,
    input  logic [ChanIdxW-1:0]  wr_chan_i,
    input  logic [cnt_width-1:0] wr_data_i,
    input  logic                 wr_now_i,
    input  logic                 align_i,
    output logic [channels-1:0]  tick_o,
    output logic [channels-1:0]  level_o,
    output logic [channels-1:0]  pend_o
);

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar g = 0; g < channels; g++) begin : g_chan
        logic wr_sel;
        assign wr_sel = wr_en_i && (wr_chan_i == ChanIdxW'(g));

        tick_channel #(
            .cnt_width (cnt_width),
            .div_init  (div_init[g])
        ) u_chan (
            .clock_i   (clock_i),
            .reset_ni  (reset_ni),
            .wr_i      (wr_sel),
            .wr_now_i  (wr_now_i),
            .wr_data_i (wr_data_i),
            .align_i   (align_i),
            .tick_o    (tick_o[g]),
            .level_o   (level_o[g]),
            .pend_o    (pend_o[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: directed scenarios plus random writes/aligns against a
// reference model that tracks each channel's next tick as an absolute cycle number.
module tb_tick_generator;

    logic        clock_i   = 1'b0;
    logic        reset_ni  = 1'b1;
    logic        wr_en_i   = 1'b0;
    logic [3:0]  wr_chan_i = '0;
    logic [15:0] wr_data_i = '0;
    logic        wr_now_i  = 1'b0;
    logic        align_i   = 1'b0;
    logic [3:0]  tick_o;
    logic [3:0]  level_o;
    logic [3:0]  pend_o;

    always #5 clock_i = ~clock_i;

    tick_generator dut (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (wr_en_i),
        .wr_chan_i (wr_chan_i),
        .wr_data_i (wr_data_i),
        .wr_now_i  (wr_now_i),
        .align_i   (align_i),
        .tick_o    (tick_o),
        .level_o   (level_o),
        .pend_o    (pend_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int init_div[4] = '{5, 20, 20, 173};
    int m_div[4];
    int m_divp[4];
    int m_next[4];
    bit m_pend[4];
    bit m_level[4];
    bit m_tick[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic void m_restart(input int ch);
        m_next[ch] = (m_div[ch] == 0) ? -1 : cyc + m_div[ch];
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_div[ch]   = init_div[ch];
            m_divp[ch]  = 0;
            m_pend[ch]  = 1'b0;
            m_level[ch] = 1'b0;
            m_tick[ch]  = 1'b0;
            m_restart(ch);
        end
    endfunction

    function automatic void model_step(input bit we, input int chan, input int data,
                                       input bit now, input bit al);
        for (int ch = 0; ch < 4; ch++) begin
            bit sel;
            sel = we && (chan == ch);
            m_tick[ch] = 1'b0;
            if (sel && (now || al || m_div[ch] == 0)) begin
                m_div[ch]  = data;
                m_pend[ch] = 1'b0;
                m_restart(ch);
            end else if (al) begin
                if (m_pend[ch]) m_div[ch] = m_divp[ch];
                m_pend[ch] = 1'b0;
                m_restart(ch);
            end else if (m_div[ch] != 0) begin
                if (cyc == m_next[ch]) begin
                    m_tick[ch]  = 1'b1;
                    m_level[ch] = ~m_level[ch];
                    if (m_pend[ch]) begin
                        m_div[ch]  = m_divp[ch];
                        m_pend[ch] = 1'b0;
                    end
                    m_restart(ch);
                end
                if (sel) begin
                    m_divp[ch] = data;
                    m_pend[ch] = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive_cycle(input logic we, input logic [3:0] chan, input logic [15:0] data,
                               input logic now, input logic al);
        logic [3:0] et, el, ep;
        wr_en_i   = we;
        wr_chan_i = chan;
        wr_data_i = data;
        wr_now_i  = now;
        align_i   = al;
        @(posedge clock_i);
        cyc++;
        model_step(we, int'(chan), int'(data), now, al);
        @(negedge clock_i);
        wr_en_i = 1'b0;
        align_i = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            et[ch] = m_tick[ch];
            el[ch] = m_level[ch];
            ep[ch] = m_pend[ch];
        end
        check_val("tick", tick_o, et);
        check_val("level", level_o, el);
        check_val("pend", pend_o, ep);
    endtask

    // Entered just after a falling edge; asserts reset between edges.
    task automatic do_reset();
        #2 reset_ni = 1'b0;
        #1;
        check_val("rst_tick", tick_o, 4'h0);
        check_val("rst_level", level_o, 4'h0);
        check_val("rst_pend", pend_o, 4'h0);
        wr_en_i = 1'b0;
        align_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_ni = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    initial begin
        @(negedge clock_i);
        do_reset();

        // Defaults after release.
        for (int i = 0; i < 350; i++) begin
            drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            case (cyc)
                4:            check_val("a_ch0_early", tick_o[0], 1'b0);
                5:  begin
                    check_val("a_ch0_t5", tick_o[0], 1'b1);
                    check_val("a_ch0_lvl_hi", level_o[0], 1'b1);
                end
                6:            check_val("a_ch0_gap", tick_o[0], 1'b0);
                10: begin
                    check_val("a_ch0_t10", tick_o[0], 1'b1);
                    check_val("a_ch0_lvl_lo", level_o[0], 1'b0);
                end
                15:           check_val("a_ch0_t15", tick_o[0], 1'b1);
                172:          check_val("a_ch3_early", tick_o[3], 1'b0);
                173, 346:     check_val("a_ch3_tick", tick_o[3], 1'b1);
                default: ;
            endcase
        end

        // Deferred write to ch1, immediate write to ch2.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (cyc + 1 == 7)       drive_cycle(1'b1, 4'd1, 16'd8, 1'b0, 1'b0);
            else if (cyc + 1 == 12) drive_cycle(1'b1, 4'd2, 16'd3, 1'b1, 1'b0);
            else                    drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            case (cyc)
                7, 19:        check_val("b_ch1_pend", pend_o[1], 1'b1);
                12: begin
                    check_val("b_ch2_suppr", tick_o[2], 1'b0);
                    check_val("b_ch2_nopend", pend_o[2], 1'b0);
                end
                15, 18, 21:   check_val("b_ch2_tick", tick_o[2], 1'b1);
                20: begin
                    check_val("b_ch1_t20", tick_o[1], 1'b1);
                    check_val("b_ch1_pclr", pend_o[1], 1'b0);
                end
                27:           check_val("b_ch1_gap", tick_o[1], 1'b0);
                28, 36:       check_val("b_ch1_tick", tick_o[1], 1'b1);
                default: ;
            endcase
        end

        // Align with counters mid-count and a pending divisor on ch3.
        do_reset();
        for (int i = 0; i < 85; i++) begin
            if (cyc + 1 == 12)      drive_cycle(1'b1, 4'd2, 16'd3, 1'b1, 1'b0);
            else if (cyc + 1 == 25) drive_cycle(1'b1, 4'd3, 16'd50, 1'b0, 1'b0);
            else if (cyc + 1 == 33) drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
            else                    drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            case (cyc)
                32:           check_val("c_ch3_pend", pend_o[3], 1'b1);
                33: begin
                    check_val("c_align_tick", tick_o, 4'h0);
                    check_val("c_align_pend", pend_o, 4'h0);
                end
                36:           check_val("c_ch2_t36", tick_o[2], 1'b1);
                37:           check_val("c_ch0_gap", tick_o[0], 1'b0);
                38:           check_val("c_ch0_t38", tick_o[0], 1'b1);
                82:           check_val("c_ch3_early", tick_o[3], 1'b0);
                83:           check_val("c_ch3_t83", tick_o[3], 1'b1);
                default: ;
            endcase
        end

        // Disable ch0, re-enable with divisor 1, then reset mid-period.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (cyc + 1 == 3)       drive_cycle(1'b1, 4'd0, 16'd0, 1'b1, 1'b0);
            else if (cyc + 1 == 13) drive_cycle(1'b1, 4'd0, 16'd1, 1'b0, 1'b0);
            else if (cyc + 1 == 21) drive_cycle(1'b1, 4'd1, 16'd9, 1'b0, 1'b0);
            else                    drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            if (cyc >= 4 && cyc <= 13) check_val("d_ch0_off", tick_o[0], 1'b0);
            if (cyc >= 4 && cyc <= 12) check_val("d_ch0_frozen", level_o[0], 1'b0);
            if (cyc >= 14 && cyc <= 20) check_val("d_ch0_div1", tick_o[0], 1'b1);
            if (cyc == 21) check_val("d_ch1_pend", pend_o[1], 1'b1);
        end
        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (cyc + 1 == 1) drive_cycle(1'b1, 4'd7, 16'd2, 1'b1, 1'b0);
            else              drive_cycle(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            if (cyc == 1) check_val("d_bad_chan_pend", pend_o, 4'h0);
            if (cyc == 5) check_val("d_ch0_restart", tick_o[0], 1'b1);
            if (cyc == 20) check_val("d_ch1_restored", tick_o[1], 1'b1);
        end

        // Random writes (including out-of-range channels) and occasional aligns.
        for (int i = 0; i < 1500; i++) begin
            logic       we, now, al;
            logic [3:0] chan;
            logic [15:0] data;
            we   = ($urandom_range(0, 3) == 0);
            chan = 4'($urandom_range(0, 7));
            data = 16'($urandom_range(0, 12));
            now  = 1'($urandom_range(0, 1));
            al   = ($urandom_range(0, 31) == 0);
            if (i == 700) do_reset();
            drive_cycle(we, chan, data, now, al);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
